// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-segment 7-segment display:
// per-digit guard/drive slots, double-buffered tear-free load, leading-zero blanking.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 50000,
  parameter int GUARD_CYCLES = 500,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int DW    = 4 * NUM_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  lz_blank,
  input  logic                  load,
  input  logic [DW-1:0]         data_in,
  output logic                  load_ack,
  output logic [3:0]            dig_code,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic [IDX_W-1:0]      scan_idx
);

  localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [3:0] BLANK = 4'hF;

  typedef enum logic {GUARD, DRIVE} state_t;

  state_t                  state_q, state_n;
  logic [CNT_W-1:0]        cnt_q, cnt_n;
  logic [IDX_W-1:0]        idx_q, idx_n;
  logic [DW-1:0]           active_q, active_n;
  logic [DW-1:0]           shadow_q;
  logic                    pending_q;
  logic                    boundary, commit;
  logic [3:0]              code_n, dig_code_n;
  logic [NUM_DIGITS-1:0]   dig_en_n;
  logic                    upper_zero;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    idx_n    = idx_q;
    boundary = 1'b0;
    if (!en) begin
      state_n = GUARD;
      cnt_n   = '0;
      idx_n   = '0;
    end else if (cnt_q == CNT_W'(SLOT_CYCLES - 1)) begin
      state_n  = GUARD;
      cnt_n    = '0;
      boundary = (idx_q == IDX_W'(NUM_DIGITS - 1));
      idx_n    = boundary ? '0 : idx_q + 1'b1;
    end else begin
      cnt_n = cnt_q + 1'b1;
      if (state_q == GUARD && cnt_q == CNT_W'(GUARD_CYCLES - 1))
        state_n = DRIVE;
    end
  end

  // The shadow only reaches the display at a frame boundary, or at once while dark.
  assign commit   = pending_q && (!en || boundary);
  assign active_n = commit ? shadow_q : active_q;

  // Outputs are computed from next-state values so the registered outputs line up with the state.
  always_comb begin
    upper_zero = ((active_n >> (4 * int'(idx_n))) == '0);
    code_n     = active_n[4*int'(idx_n) +: 4];
    if (lz_blank && idx_n != '0 && upper_zero)
      code_n = BLANK;
    dig_code_n = en ? code_n : BLANK;
    dig_en_n   = '0;
    if (en && state_n == DRIVE)
      dig_en_n = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_n;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= GUARD;
      cnt_q     <= '0;
      idx_q     <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      dig_en    <= '0;
      dig_code  <= BLANK;
      load_ack  <= 1'b0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      idx_q    <= idx_n;
      active_q <= active_n;
      load_ack <= commit;
      dig_en   <= dig_en_n;
      dig_code <= dig_code_n;
      // A load on the commit cycle lands in the shadow and stays pending for the next boundary.
      if (load) begin
        shadow_q  <= data_in;
        pending_q <= 1'b1;
      end else if (commit) begin
        pending_q <= 1'b0;
      end
    end
  end

  assign scan_idx = idx_q;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexing scan controller for a multi-digit common-segment 7-segment display. It drives one shared BCD-to-7-segment decoder. Each cycle it selects one digit's 4-bit code, presents it on the decoder input and enables that digit's common line. Inter-digit blanking suppresses ghosting. A double-buffered load interface makes value updates tear-free at frame boundaries. Optional leading-zero suppression is supported.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8).
SLOT_CYCLES, 50000, clock cycles each digit occupies per frame (>= GUARD_CYCLES+1).
GUARD_CYCLES, 500, cycles at slot start with all digit enables low (>= 1).

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous active-high reset.
en  in  1  scan enable; 0 = display dark, scan held at start.
lz_blank  in  1  1 = suppress leading zeros.
load  in  1  single-cycle strobe: capture data_in into shadow register.
data_in  in  4*NUM_DIGITS  BCD digits, digit 0 = bits [3:0] (least significant, rightmost).
load_ack  out  1  one-cycle pulse when shadow value becomes the displayed value.
dig_code  out  4  code to shared decoder; 4'hF = blank (decoder outputs all-off for codes > 9).
dig_en  out  NUM_DIGITS  one-hot active-high digit enable.
scan_idx  out  clog2(NUM_DIGITS)  index of digit currently selected.

Behaviour:
- Reset (async, immediate):
  - slot counter=0, scan_idx=0, state=GUARD.
  - active and shadow registers=0, pending=0.
  - dig_en=0, dig_code=4'hF, load_ack=0.
- All outputs are registered.
- FSM states:
  - GUARD: dig_en=0, dig_code=code of scan_idx (pre-settles decoder).
  - DRIVE: dig_en=one-hot(scan_idx).
- Slot counter runs 0..SLOT_CYCLES-1.
  - GUARD -> DRIVE when counter reaches GUARD_CYCLES-1.
  - DRIVE -> GUARD when counter reaches SLOT_CYCLES-1. At that point the counter wraps to 0 and scan_idx increments.
- scan_idx wraps NUM_DIGITS-1 -> 0. That wrap is the frame boundary.
- Frame period = NUM_DIGITS*SLOT_CYCLES cycles.
- Load handshake:
  - load=1 copies data_in into shadow and sets pending=1.
  - A later load before commit overwrites the shadow; only the latest value is committed.
- Commit: at the frame boundary cycle with pending=1:
  - active<=shadow, pending<=0, load_ack=1 for exactly that cycle.
  - The new value is first driven on digit 0 of the next frame.
- Load on the boundary cycle itself: the boundary commits the shadow as it stood before that cycle. The new data goes into shadow, pending stays 1, and commit happens at the next boundary. If pending was 0, no ack is issued this boundary.
- Leading-zero blanking (lz_blank=1): digit i shows 4'hF if active digits NUM_DIGITS-1 down to i are all 0. Digit 0 is never blanked, so value 0 shows a single "0".
- lz_blank=0: all digits are shown raw. Codes A..F pass through unchanged, and the decoder shows them blank.
- en=0 (sampled each cycle):
  - counter=0, scan_idx=0, state=GUARD, dig_en=0, dig_code=4'hF.
  - load is still accepted. While en=0 a pending shadow commits immediately the next cycle, with load_ack pulsed.
- en 0->1: scanning starts at slot 0 in GUARD.
- Digit enables are never active during the GUARD portion. No two dig_en bits are ever high simultaneously.

Test Plan:
Setup for all scenarios: NUM_DIGITS=4, SLOT_CYCLES=8, GUARD_CYCLES=2.
- Reset/basic scan: rst pulse, en=1, load data_in=16'h1234 while en=0.
  - load_ack is seen next cycle.
  - Then per slot: 2 cycles dig_en=0, 6 cycles dig_en=0001/0010/0100/1000 with dig_code=4/3/2/1 respectively.
  - Frame repeats every 32 cycles.
- Tear-free update: during scan of 16'h1234, load 16'h5678 mid-frame (scan_idx=1).
  - Digits 2,3 still show 2,1.
  - load_ack pulses on the boundary cycle.
  - Next frame shows 8,7,6,5.
- Boundary collision: load 16'h1111 at cycle X, then load 16'h2222 exactly on the boundary cycle.
  - Ack at the boundary; frame shows 1111.
  - Second ack one frame later; frame then shows 2222.
- Leading zeros: active=16'h0050, lz_blank=1 -> codes F,F,5,0 for digits 3..0. active=16'h0000 -> F,F,F,0. lz_blank=0 -> 0,0,5,0.
- Async reset mid-DRIVE: assert rst with dig_en=0100.
  - Outputs go to reset values the same instant, without waiting for a clock edge.
  - After release, the display is all blank-zero until a new load commits.
- Enable drop: en=0 during slot 2 -> dig_en=0 next cycle. en=1 -> scan resumes at scan_idx=0 in GUARD.
